// File: rtl/addsub_pipe_if.sv
// Operand/result bus of the pipelined add/subtract unit.
// The issue side drives operands and out_ready; the unit drives results and in_ready.
interface addsub_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             neg;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, cout, ovf, zero, neg
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, cout, ovf, zero, neg
    );
endinterface

// File: rtl/addsub_pipe.sv
// Pipelined signed add/subtract with status flags and valid/ready flow control.
// Optional macro ADDSUB_SATURATE_EN clamps overflowed results to the signed limits.
module addsub_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    addsub_pipe_if.slave bus
);
    localparam int MSB = WIDTH - 1;

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum_d;
    logic [WIDTH-1:0] res_d;
    logic             cout_d;
    logic             ovf_d;
    logic             zero_d;
    logic             neg_d;

    logic             vld_q [STAGES];
    logic [WIDTH-1:0] res_q [STAGES];
    logic [3:0]       flg_q [STAGES];   // {cout, ovf, zero, neg}
    logic [STAGES-1:0] en;

`ifdef ADDSUB_SATURATE_EN
    // Overflow direction follows the sign of A: a non-negative A can only overflow upward.
    function automatic logic signed [WIDTH-1:0] sat_fn(
        input logic signed [WIDTH-1:0] raw,
        input logic                    ovf,
        input logic                    a_neg
    );
        logic signed [WIDTH-1:0] lim_max;
        logic signed [WIDTH-1:0] lim_min;
        lim_max = {1'b0, {(WIDTH-1){1'b1}}};
        lim_min = {1'b1, {(WIDTH-1){1'b0}}};
        if (!ovf) return raw;
        return a_neg ? lim_min : lim_max;
    endfunction
`endif

    // Stage 0 input: all arithmetic is resolved before the first register
    always_comb begin
        b_eff  = bus.op ? bus.b : ~bus.b;
        sum_d  = {1'b0, bus.a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, ~bus.op};
        cout_d = sum_d[WIDTH];
        if (bus.op)
            ovf_d = (bus.a[MSB] == bus.b[MSB]) && (sum_d[MSB] != bus.a[MSB]);
        else
            ovf_d = (bus.a[MSB] != bus.b[MSB]) && (sum_d[MSB] != bus.a[MSB]);
`ifdef ADDSUB_SATURATE_EN
        res_d = sat_fn(sum_d[WIDTH-1:0], ovf_d, bus.a[MSB]);
`else
        res_d = sum_d[WIDTH-1:0];
`endif
        zero_d = (res_d == '0);
        neg_d  = res_d[MSB];
    end

    // A stage may load when it is empty or its contents move on this cycle.
    always_comb begin : en_chain
        logic chain;
        chain          = ~vld_q[STAGES-1] | bus.out_ready;
        en             = '0;
        en[STAGES-1]   = chain;
        for (int i = STAGES - 2; i >= 0; i--) begin
            chain = ~vld_q[i] | chain;
            en[i] = chain;
        end
    end

    // Stage 0 captures the computed beat; stages 1..STAGES-1 are pure delay
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                vld_q[i] <= 1'b0;
                res_q[i] <= '0;
                flg_q[i] <= '0;
            end
        end else begin
            if (en[0]) begin
                vld_q[0] <= bus.in_valid;
                res_q[0] <= res_d;
                flg_q[0] <= {cout_d, ovf_d, zero_d, neg_d};
            end
            for (int i = 1; i < STAGES; i++) begin
                if (en[i]) begin
                    vld_q[i] <= vld_q[i-1];
                    res_q[i] <= res_q[i-1];
                    flg_q[i] <= flg_q[i-1];
                end
            end
        end
    end

    assign bus.in_ready  = en[0];
    assign bus.out_valid = vld_q[STAGES-1];
    assign bus.result    = res_q[STAGES-1];
    assign bus.cout      = flg_q[STAGES-1][3];
    assign bus.ovf       = flg_q[STAGES-1][2];
    assign bus.zero      = flg_q[STAGES-1][1];
    assign bus.neg       = flg_q[STAGES-1][0];
endmodule

// File: tb/tb_addsub_pipe.sv
// Directed bench for addsub_pipe: 8-bit/2-stage main instance plus 16-bit 1- and 4-stage instances.
module tb_addsub_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    addsub_pipe_if #(.WIDTH(8))  b8();
    addsub_pipe_if #(.WIDTH(16)) b16a();
    addsub_pipe_if #(.WIDTH(16)) b16d();

    addsub_pipe #(.WIDTH(8),  .STAGES(2)) dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));
    addsub_pipe #(.WIDTH(16), .STAGES(1)) dut16a(.clk(clk), .rst_n(rst_n), .bus(b16a));
    addsub_pipe #(.WIDTH(16), .STAGES(4)) dut16d(.clk(clk), .rst_n(rst_n), .bus(b16d));

`ifdef ADDSUB_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res_w;
        logic [7:0] res_s;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t vt [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]  e8;
        logic [15:0] e16;
        int exp6 [6];
        int sent, rcv, lat1, lat4;

        vt[0]  = '{1'b0, 8'd69,  8'd42,  8'h1B, 8'h1B, 1'b1, 1'b0};
        vt[1]  = '{1'b0, 8'd42,  8'd69,  8'hE5, 8'hE5, 1'b0, 1'b0};
        vt[2]  = '{1'b0, 8'h00,  8'h7F,  8'h81, 8'h81, 1'b0, 1'b0};
        vt[3]  = '{1'b0, 8'h80,  8'h01,  8'h7F, 8'h80, 1'b1, 1'b1};
        vt[4]  = '{1'b1, 8'd100, 8'd100, 8'hC8, 8'h7F, 1'b0, 1'b1};
        vt[5]  = '{1'b1, 8'hFB,  8'h05,  8'h00, 8'h00, 1'b1, 1'b0};
        vt[6]  = '{1'b1, 8'h80,  8'h80,  8'h00, 8'h80, 1'b1, 1'b1};
        vt[7]  = '{1'b0, 8'h05,  8'h05,  8'h00, 8'h00, 1'b1, 1'b0};
        vt[8]  = '{1'b1, 8'h7F,  8'h01,  8'h80, 8'h7F, 1'b0, 1'b1};
        vt[9]  = '{1'b0, 8'h00,  8'h80,  8'h80, 8'h7F, 1'b0, 1'b1};
        vt[10] = '{1'b1, 8'hFF,  8'hFF,  8'hFE, 8'hFE, 1'b1, 1'b0};
        exp6 = '{1, 12, 23, 34, 45, 56};

        b8.in_valid = 1'b0;   b8.op = 1'b0;   b8.a = '0;   b8.b = '0;   b8.out_ready = 1'b1;
        b16a.in_valid = 1'b0; b16a.op = 1'b0; b16a.a = '0; b16a.b = '0; b16a.out_ready = 1'b1;
        b16d.in_valid = 1'b0; b16d.op = 1'b0; b16d.a = '0; b16d.b = '0; b16d.out_ready = 1'b1;

        // Reset state
        #12;
        chk("rst_out_valid", 32'(b8.out_valid), 0);
        chk("rst_result",    32'(b8.result), 0);
        chk("rst_flags",     32'({b8.cout, b8.ovf, b8.zero, b8.neg}), 0);
        chk("rst_s1_valid",  32'(b16a.out_valid), 0);
        chk("rst_s4_valid",  32'(b16d.out_valid), 0);
        step();
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready",    32'(b8.in_ready), 1);
        chk("rst_s4_in_ready", 32'(b16d.in_ready), 1);

        // Table-driven single beats, out_ready held high
        for (int i = 0; i < 11; i++) begin
            e8 = SAT ? vt[i].res_s : vt[i].res_w;
            b8.op = vt[i].op; b8.a = vt[i].a; b8.b = vt[i].b; b8.in_valid = 1'b1;
            #1;
            chk($sformatf("v%0d_in_ready", i), 32'(b8.in_ready), 1);
            step();
            b8.in_valid = 1'b0;
            chk($sformatf("v%0d_early", i), 32'(b8.out_valid), 0);
            step();
            chk($sformatf("v%0d_valid", i),  32'(b8.out_valid), 1);
            chk($sformatf("v%0d_result", i), 32'(b8.result), 32'(e8));
            chk($sformatf("v%0d_cout", i),   32'(b8.cout), 32'(vt[i].cout));
            chk($sformatf("v%0d_ovf", i),    32'(b8.ovf), 32'(vt[i].ovf));
            chk($sformatf("v%0d_zero", i),   32'(b8.zero), 32'(e8 == 8'h00));
            chk($sformatf("v%0d_neg", i),    32'(b8.neg), 32'(e8[7]));
        end
        step();

        // Six-beat stream with a four-cycle downstream stall
        sent = 0;
        rcv  = 0;
        for (int cyc = 0; cyc < 30 && rcv < 6; cyc++) begin
            b8.out_ready = !(cyc >= 3 && cyc <= 6);
            if (sent < 6) begin
                b8.in_valid = 1'b1; b8.op = 1'b1;
                b8.a = 8'(10 * sent + 1); b8.b = 8'(sent);
            end else begin
                b8.in_valid = 1'b0;
            end
            #1;
            if (!b8.out_ready) begin
                chk("stall_in_ready", 32'(b8.in_ready), 0);
                chk("stall_valid",    32'(b8.out_valid), 1);
                chk("stall_hold",     32'(b8.result), 12);
            end
            if (b8.out_valid && b8.out_ready) begin
                chk($sformatf("stream_res%0d", rcv), 32'(b8.result), 32'(exp6[rcv]));
                if (rcv >= 1) chk($sformatf("stream_rate%0d", rcv), 32'(cyc), 32'(6 + rcv));
                rcv++;
            end
            if (b8.in_valid && b8.in_ready) sent++;
            step();
        end
        b8.in_valid = 1'b0;
        b8.out_ready = 1'b1;
        chk("stream_rcv_count",  32'(rcv), 6);
        chk("stream_sent_count", 32'(sent), 6);

        // Reset with two beats in flight
        b8.out_ready = 1'b0;
        b8.op = 1'b1; b8.a = 8'd3; b8.b = 8'd4; b8.in_valid = 1'b1;
        step();
        b8.a = 8'd7; b8.b = 8'd8;
        step();
        b8.in_valid = 1'b0;
        chk("midrst_pre_valid", 32'(b8.out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid",  32'(b8.out_valid), 0);
        chk("midrst_result", 32'(b8.result), 0);
        chk("midrst_flags",  32'({b8.cout, b8.ovf, b8.zero, b8.neg}), 0);
        step();
        rst_n = 1'b1;
        b8.out_ready = 1'b1;
        #1;
        chk("midrst_in_ready", 32'(b8.in_ready), 1);
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("midrst_ghost%0d", k), 32'(b8.out_valid), 0);
        end
        b8.op = 1'b0; b8.a = 8'd50; b8.b = 8'd8; b8.in_valid = 1'b1;
        step();
        b8.in_valid = 1'b0;
        chk("postrst_early",  32'(b8.out_valid), 0);
        step();
        chk("postrst_valid",  32'(b8.out_valid), 1);
        chk("postrst_result", 32'(b8.result), 32'h2A);
        chk("postrst_cout",   32'(b8.cout), 1);

        // 16-bit, STAGES=1 and STAGES=4: 0x8000 - 0x0001
        e16 = SAT ? 16'h8000 : 16'h7FFF;
        b16a.op = 1'b0; b16a.a = 16'h8000; b16a.b = 16'h0001; b16a.in_valid = 1'b1;
        b16d.op = 1'b0; b16d.a = 16'h8000; b16d.b = 16'h0001; b16d.in_valid = 1'b1;
        step();
        b16a.in_valid = 1'b0;
        b16d.in_valid = 1'b0;
        lat1 = -1;
        lat4 = -1;
        for (int c = 1; c <= 8; c++) begin
            if (b16a.out_valid && lat1 < 0) begin
                lat1 = c;
                chk("s1_result", 32'(b16a.result), 32'(e16));
                chk("s1_ovf",    32'(b16a.ovf), 1);
                chk("s1_cout",   32'(b16a.cout), 1);
                chk("s1_neg",    32'(b16a.neg), 32'(e16[15]));
            end
            if (b16d.out_valid && lat4 < 0) begin
                lat4 = c;
                chk("s4_result", 32'(b16d.result), 32'(e16));
                chk("s4_ovf",    32'(b16d.ovf), 1);
                chk("s4_zero",   32'(b16d.zero), 0);
            end
            step();
        end
        chk("s1_latency", 32'(lat1), 1);
        chk("s4_latency", 32'(lat4), 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
